exe_wb_stage: RTL and testbench
===============================

// Module: exe_wb_stage
// PURPOSE
//   Execute stage plus EXE/WB pipeline register. Consumes the operand bundle
//   (rdata1, rdata2, imm, opcode, waddr) launched by the ID/EXE register.
//   Computes the ALU result and drives the register-file write port one cycle
//   later. MUL is a multi-cycle shift-add operation; while it runs, the block
//   raises stall to freeze the upstream ID/EXE register and the IF/ID register.
// PARAMETERS
//   DSIZE  32  datapath width; operands, immediate and result
//   ASIZE  5   register-file address width
// PORTS
//   clk         in   1      single clock, rising edge
//   rst_n       in   1      asynchronous reset, active low
//   valid_in    in   1      operand bundle on *_in is a real instruction
//   rdata1_in   in   DSIZE  source operand A
//   rdata2_in   in   DSIZE  source operand B (R-type)
//   imm_in      in   DSIZE  sign-extended immediate (I-type)
//   opcode_in   in   3      operation select, see BEHAVIOUR
//   waddr_in    in   ASIZE  destination register
//   stall       out  1      1 = hold upstream stages and do not present a new bundle
//   wen         out  1      register-file write enable, 1-cycle pulse per result
//   waddr_out   out  ASIZE  write address, valid when wen=1
//   wdata_out   out  DSIZE  write data, valid when wen=1
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, wen=0, waddr_out=0, wdata_out=0,
//     stall=0, multiply accumulator/counter=0. A MUL in flight is discarded
//     with no write.
//   Opcodes: 000 ADD A+B | 001 SUB A-B | 010 AND | 011 OR | 100 XOR |
//     101 ADDI A+imm | 110 SLT (signed A<B ? 1 : 0) | 111 MUL (low DSIZE bits of A*B).
//   Arithmetic is modulo 2^DSIZE and drops carries and overflow. SLT is zero-extended.
//   FSM states: IDLE, MUL.
//   IDLE behaviour:
//     - valid_in=1, opcode != 111: at the next edge, wen<=1, waddr_out<=waddr_in,
//       wdata_out<=result. Latency is 1 cycle. State stays IDLE.
//     - valid_in=1, opcode = 111, accepted at edge E0: latch A, B and waddr.
//       Clear the accumulator, set cnt=0, go to MUL, wen<=0.
//     - valid_in=0: wen<=0 at the next edge. waddr_out and wdata_out hold their values.
//   MUL behaviour:
//     - Each edge processes one multiplier bit (LSB first):
//       acc += B[cnt] ? (A<<cnt) : 0; cnt++.
//     - At edge E_DSIZE, i.e. after DSIZE iterations:
//       wen<=1, wdata_out<=acc final, waddr_out<=latched waddr, state<=IDLE.
//     - valid_in and the *_in buses are ignored in MUL.
//   stall = (state==MUL), combinational from the state register. It is high for
//     exactly DSIZE cycles, from after E0 until E_DSIZE. A bundle presented in the
//     cycle after E_DSIZE is accepted normally; back-to-back MULs are allowed.
//   waddr 0 is hardwired zero: any result targeting address 0 gives wen=0.
//     The FSM still runs the MUL timing for such an instruction.
//   wen is never high for two cycles from one instruction.
//   Back-to-back single-cycle ops produce consecutive wen pulses.
//   Reset asserted during MUL: immediate return to IDLE, stall drops
//     asynchronously, no write.
// TESTING
//   1. Run ADD A=5,B=7,waddr=3, then SUB A=3,B=5,waddr=4 back-to-back.
//      Required: wen on 2 consecutive cycles, (3,0x0000000C) then (4,0xFFFFFFFE).
//   2. Run SLT A=0xFFFFFFFF,B=1,waddr=2, then ADDI A=10,imm=0xFFFFFFFF,waddr=2.
//      Required: wdata 1 then 9, each 1 cycle after issue.
//   3. Run MUL A=7,B=6,waddr=9, then hold an ADD bundle.
//      Required: stall=1 for exactly 32 cycles, wen with (9,42) at E32,
//      then the ADD result one cycle later.
//   4. Run MUL A=0x00010000,B=0x00010001, then MUL A=0xFFFFFFFF,B=0xFFFFFFFF.
//      Required: results 0x00010000 and 0x00000001 (wrap).
//   5. Send ADD and MUL to waddr=0, and send valid_in=0 bundles.
//      Required: wen never asserts. MUL still stalls 32 cycles.
//   6. Assert rst_n=0 at cnt=10 of a MUL.
//      Required: stall=0, wen=0, outputs 0 immediately. After release,
//      ADD 1+1 → wdata 2 with no stale write.

Source files
------------

// File: rtl/exe_wb_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | exe_wb_stage: ALU execute stage with EXE/WB register and shift-add MUL.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module exe_wb_stage #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [DSIZE-1:0] rdata1_in,
  input  logic [DSIZE-1:0] rdata2_in,
  input  logic [DSIZE-1:0] imm_in,
  input  logic [2:0]       opcode_in,
  input  logic [ASIZE-1:0] waddr_in,
  output logic             stall,
  output logic             wen,
  output logic [ASIZE-1:0] waddr_out,
  output logic [DSIZE-1:0] wdata_out
);

  localparam int                 c_CNT_W = (DSIZE > 1) ? $clog2(DSIZE) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DSIZE - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  localparam logic [2:0] c_OP_ADD  = 3'b000;
  localparam logic [2:0] c_OP_SUB  = 3'b001;
  localparam logic [2:0] c_OP_AND  = 3'b010;
  localparam logic [2:0] c_OP_OR   = 3'b011;
  localparam logic [2:0] c_OP_XOR  = 3'b100;
  localparam logic [2:0] c_OP_ADDI = 3'b101;
  localparam logic [2:0] c_OP_SLT  = 3'b110;
  localparam logic [2:0] c_OP_MUL  = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_wen, w_wen_nxt;
  logic [ASIZE-1:0]   r_waddr, w_waddr_nxt;
  logic [DSIZE-1:0]   r_wdata, w_wdata_nxt;
  logic [DSIZE-1:0]   r_mul_a, w_mul_a_nxt;
  logic [DSIZE-1:0]   r_mul_b, w_mul_b_nxt;
  logic [DSIZE-1:0]   r_acc, w_acc_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [ASIZE-1:0]   r_mul_waddr, w_mul_waddr_nxt;

  logic [DSIZE-1:0]   w_alu;
  logic [DSIZE-1:0]   w_mul_sum;
  logic               w_slt;

  assign w_slt = $signed(rdata1_in) < $signed(rdata2_in);

  always_comb begin
    w_alu = '0;
    case (opcode_in)
      c_OP_ADD:  w_alu = rdata1_in + rdata2_in;
      c_OP_SUB:  w_alu = rdata1_in - rdata2_in;
      c_OP_AND:  w_alu = rdata1_in & rdata2_in;
      c_OP_OR:   w_alu = rdata1_in | rdata2_in;
      c_OP_XOR:  w_alu = rdata1_in ^ rdata2_in;
      c_OP_ADDI: w_alu = rdata1_in + imm_in;
      c_OP_SLT:  w_alu = {{(DSIZE-1){1'b0}}, w_slt};
      default:   w_alu = '0;
    endcase
  end

  // Multiplicand shifts left and multiplier shifts right each step, so bit 0
  // of r_mul_b is always multiplier bit cnt and r_mul_a is A<<cnt.
  assign w_mul_sum = r_acc + (r_mul_b[0] ? r_mul_a : '0);

  always_comb begin
    w_state_nxt     = r_state;
    w_wen_nxt       = 1'b0;
    w_waddr_nxt     = r_waddr;
    w_wdata_nxt     = r_wdata;
    w_mul_a_nxt     = r_mul_a;
    w_mul_b_nxt     = r_mul_b;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_mul_waddr_nxt = r_mul_waddr;
    case (r_state)
      ST_IDLE: begin
        if (valid_in) begin
          if (opcode_in == c_OP_MUL) begin
            w_mul_a_nxt     = rdata1_in;
            w_mul_b_nxt     = rdata2_in;
            w_mul_waddr_nxt = waddr_in;
            w_acc_nxt       = '0;
            w_cnt_nxt       = '0;
            w_state_nxt     = ST_MUL;
          end else if (waddr_in != '0) begin
            w_wen_nxt   = 1'b1;
            w_waddr_nxt = waddr_in;
            w_wdata_nxt = w_alu;
          end
        end
      end
      ST_MUL: begin
        w_acc_nxt   = w_mul_sum;
        w_mul_a_nxt = r_mul_a << 1;
        w_mul_b_nxt = r_mul_b >> 1;
        w_cnt_nxt   = r_cnt + c_ONE;
        if (r_cnt == c_LAST) begin
          w_state_nxt = ST_IDLE;
          // Register 0 is hardwired: the timing still runs but nothing is written.
          if (r_mul_waddr != '0) begin
            w_wen_nxt   = 1'b1;
            w_waddr_nxt = r_mul_waddr;
            w_wdata_nxt = w_mul_sum;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wen       <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_mul_waddr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wen       <= w_wen_nxt;
      r_waddr     <= w_waddr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_mul_a     <= w_mul_a_nxt;
      r_mul_b     <= w_mul_b_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mul_waddr <= w_mul_waddr_nxt;
    end
  end

  assign stall     = (r_state == ST_MUL);
  assign wen       = r_wen;
  assign waddr_out = r_waddr;
  assign wdata_out = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_exe_wb_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_exe_wb_stage: directed and random checks against a behavioural model. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_exe_wb_stage;

  localparam int DSIZE = 32;
  localparam int ASIZE = 5;
  localparam int MUL_CYCLES = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             valid_in;
  logic [DSIZE-1:0] rdata1_in, rdata2_in, imm_in;
  logic [2:0]       opcode_in;
  logic [ASIZE-1:0] waddr_in;
  logic             stall, wen;
  logic [ASIZE-1:0] waddr_out;
  logic [DSIZE-1:0] wdata_out;

  exe_wb_stage #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .imm_in(imm_in),
    .opcode_in(opcode_in), .waddr_in(waddr_in),
    .stall(stall), .wen(wen), .waddr_out(waddr_out), .wdata_out(wdata_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: cycles of multiply still outstanding and the pending result.
  int               busy_left;
  logic [ASIZE-1:0] pend_wa;
  logic [DSIZE-1:0] pend_wd;
  logic             exp_wen;
  logic [ASIZE-1:0] exp_wa;
  logic [DSIZE-1:0] exp_wd;
  logic             last_accepted;

  logic [ASIZE-1:0] log_wa [$];
  logic [DSIZE-1:0] log_wd [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DSIZE-1:0] ref_alu(input logic [2:0] op, input logic [DSIZE-1:0] a,
                                               input logic [DSIZE-1:0] b, input logic [DSIZE-1:0] imm);
    logic [63:0] p;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a + imm;
      3'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
      end
    endcase
  endfunction

  // One clock cycle starting and ending at a falling edge.
  task automatic run_cycle(input logic v, input logic [2:0] op, input logic [DSIZE-1:0] a,
                           input logic [DSIZE-1:0] b, input logic [DSIZE-1:0] imm,
                           input logic [ASIZE-1:0] wa);
    valid_in = v; opcode_in = op; rdata1_in = a; rdata2_in = b; imm_in = imm; waddr_in = wa;
    check("stall", {63'd0, stall}, {63'd0, busy_left != 0});
    last_accepted = 1'b0;
    exp_wen = 1'b0;
    if (busy_left != 0) begin
      busy_left--;
      if (busy_left == 0 && pend_wa != 0) begin
        exp_wen = 1'b1; exp_wa = pend_wa; exp_wd = pend_wd;
      end
    end else if (v) begin
      last_accepted = 1'b1;
      if (op == 3'd7) begin
        busy_left = MUL_CYCLES; pend_wa = wa; pend_wd = ref_alu(op, a, b, imm);
      end else if (wa != 0) begin
        exp_wen = 1'b1; exp_wa = wa; exp_wd = ref_alu(op, a, b, imm);
      end
    end
    @(posedge clk); #1;
    check("wen", {63'd0, wen}, {63'd0, exp_wen});
    if (exp_wen) begin
      check("waddr", {59'd0, waddr_out}, {59'd0, exp_wa});
      check("wdata", {32'd0, wdata_out}, {32'd0, exp_wd});
    end
    if (wen) begin
      log_wa.push_back(waddr_out);
      log_wd.push_back(wdata_out);
    end
    @(negedge clk);
  endtask

  // Hold a bundle until the stage accepts it.
  task automatic issue(input logic [2:0] op, input logic [DSIZE-1:0] a, input logic [DSIZE-1:0] b,
                       input logic [DSIZE-1:0] imm, input logic [ASIZE-1:0] wa);
    int tries = 0;
    do begin
      run_cycle(1'b1, op, a, b, imm, wa);
      tries++;
    end while (!last_accepted && tries < 64);
    if (!last_accepted) check("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0);
  endtask

  initial begin
    int base;
    int stall_cnt;
    rst_n = 1'b0; valid_in = 1'b0; opcode_in = '0; waddr_in = '0;
    rdata1_in = '0; rdata2_in = '0; imm_in = '0;
    busy_left = 0; pend_wa = '0; pend_wd = '0;
    repeat (2) @(negedge clk);
    check("rst_wen", {63'd0, wen}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_waddr", {59'd0, waddr_out}, 64'd0);
    check("rst_wdata", {32'd0, wdata_out}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back ADD / SUB
    issue(3'd0, 32'd5, 32'd7, 32'd0, 5'd3);
    issue(3'd1, 32'd3, 32'd5, 32'd0, 5'd4);
    check("t1_n", log_wd.size(), 2);
    check("t1_add", {32'd0, log_wd[0]}, 64'h0000_000C);
    check("t1_sub", {32'd0, log_wd[1]}, 64'hFFFF_FFFE);
    check("t1_sub_wa", {59'd0, log_wa[1]}, 64'd4);

    // SLT signed, ADDI with negative immediate
    issue(3'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd2);
    check("t2_slt", {32'd0, log_wd[log_wd.size()-1]}, 64'd1);
    issue(3'd5, 32'd10, 32'd0, 32'hFFFF_FFFF, 5'd2);
    check("t2_addi", {32'd0, log_wd[log_wd.size()-1]}, 64'd9);

    // MUL followed by a held ADD
    base = log_wd.size();
    issue(3'd7, 32'd7, 32'd6, 32'd0, 5'd9);
    stall_cnt = 0;
    for (int i = 0; i < 40 && stall; i++) begin
      stall_cnt++;
      run_cycle(1'b1, 3'd0, 32'd100, 32'd23, 32'd0, 5'd11);
    end
    check("t3_stall_len", stall_cnt, MUL_CYCLES);
    issue(3'd0, 32'd100, 32'd23, 32'd0, 5'd11);
    check("t3_n", log_wd.size() - base, 2);
    check("t3_mul", {32'd0, log_wd[base]}, 64'd42);
    check("t3_mul_wa", {59'd0, log_wa[base]}, 64'd9);
    check("t3_add", {32'd0, log_wd[base+1]}, 64'd123);

    // Back-to-back MULs with wrap
    issue(3'd7, 32'h0001_0000, 32'h0001_0001, 32'd0, 5'd7);
    issue(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'd8);
    idle(MUL_CYCLES);
    check("t4_mul1", {32'd0, log_wd[log_wd.size()-2]}, 64'h0001_0000);
    check("t4_mul2", {32'd0, log_wd[log_wd.size()-1]}, 64'h0000_0001);

    // Writes to register 0 and invalid bundles never assert wen
    base = log_wd.size();
    issue(3'd0, 32'd1, 32'd2, 32'd0, 5'd0);
    issue(3'd7, 32'd3, 32'd4, 32'd0, 5'd0);
    stall_cnt = 0;
    for (int i = 0; i < 40 && stall; i++) begin
      stall_cnt++;
      run_cycle(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd6);
    end
    check("t5_stall_len", stall_cnt, MUL_CYCLES);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 3'd0, 32'd9, 32'd9, 32'd0, 5'd6);
    check("t5_nowrite", log_wd.size() - base, 0);

    // Reset in the middle of a MUL
    issue(3'd7, 32'd5, 32'd5, 32'd0, 5'd12);
    idle(10);
    rst_n = 1'b0;
    #1;
    check("t6_stall", {63'd0, stall}, 64'd0);
    check("t6_wen", {63'd0, wen}, 64'd0);
    check("t6_waddr", {59'd0, waddr_out}, 64'd0);
    check("t6_wdata", {32'd0, wdata_out}, 64'd0);
    busy_left = 0;
    @(negedge clk);
    rst_n = 1'b1;
    base = log_wd.size();
    issue(3'd0, 32'd1, 32'd1, 32'd0, 5'd13);
    idle(MUL_CYCLES + 4);
    check("t6_n", log_wd.size() - base, 1);
    check("t6_add", {32'd0, log_wd[base]}, 64'd2);

    // Random traffic, bundles keep changing while stalled
    for (int i = 0; i < 400; i++) begin
      logic [ASIZE-1:0] wa;
      wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, wa);
    end
    idle(MUL_CYCLES + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
